// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate path: the select-code encodings that
// the execute-stage selector also uses, the MIPS-I opcode/funct constants,
// the decoded operand bundle and the occupancy states.
package imm_gen_pkg;

  // Immediate-mux select codes
  localparam logic [1:0] IMM_SRC_IMM   = 2'b00;
  localparam logic [1:0] IMM_SRC_SHAMT = 2'b01;
  localparam logic [1:0] IMM_SRC_DBL   = 2'b10;

  // Opcodes (INSTR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type functs (INSTR[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] shamt;
    logic [31:0] dbl;
    logic [1:0]  ctl;
  } imm_ops_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/imm_gen_decode.sv
// imm_decode: pure combinational INSTR -> {IMM, SHAMT, DBL, CTL}.
// Unknown opcodes fall through to a sign-extended IMM with CTL = IMM_SRC_IMM.
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [31:0] i_instr,
  output imm_ops_t    o_ops
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [15:0] w_imm16;
  logic        w_unused_regs;

  assign w_opcode      = i_instr[31:26];
  assign w_funct       = i_instr[5:0];
  assign w_imm16       = i_instr[15:0];
  // rs/rt fields carry no operand information for this block
  assign w_unused_regs = ^i_instr[25:16];

  // Decode the three candidate operands and the select code
  always_comb begin
    o_ops.shamt = {27'd0, i_instr[10:6]};
    o_ops.dbl   = {w_imm16, 16'h0000};
    if ((w_opcode == OP_ANDI) || (w_opcode == OP_ORI) || (w_opcode == OP_XORI))
      o_ops.imm = {16'h0000, w_imm16};
    else
      o_ops.imm = {{16{w_imm16[15]}}, w_imm16};

    o_ops.ctl = IMM_SRC_IMM;
    if (w_opcode == OP_LUI)
      o_ops.ctl = IMM_SRC_DBL;
    else if ((w_opcode == OP_RTYPE) &&
             ((w_funct == FN_SLL) || (w_funct == FN_SRL) || (w_funct == FN_SRA)))
      o_ops.ctl = IMM_SRC_SHAMT;
  end

endmodule

// File: rtl/imm_gen.sv
// imm_gen: registered immediate-operand producer with a one-entry skid buffer.
// Optional saturating per-category transfer counters: `define IMM_GEN_STATS_EN.
module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int SKID_EN_DEPTH = 1,
  parameter int STAT_W        = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] INSTR,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [31:0] IMM,
  output logic [31:0] SHAMT,
  output logic [31:0] DBL,
  output logic [1:0]  CTL,
  output logic        OUT_VALID,
  input  logic        OUT_READY
`ifdef IMM_GEN_STATS_EN
  ,
  input  logic              STAT_CLR,
  output logic [STAT_W-1:0] STAT_IMM,
  output logic [STAT_W-1:0] STAT_SHAMT,
  output logic [STAT_W-1:0] STAT_DBL
`endif
);

  if (SKID_EN_DEPTH != 1) begin : g_bad_depth
    $error("imm_gen supports exactly one skid entry");
  end

  imm_ops_t   w_dec;
  imm_ops_t   r_out;
  imm_ops_t   r_skid;
  occ_state_e r_state;
  occ_state_e w_state_nxt;
  logic       r_in_ready;
  logic       r_out_valid;
  logic       w_accept;
  logic       w_drain;
  logic       w_load_out_dec;
  logic       w_load_out_skid;
  logic       w_load_skid;

  imm_decode u_decode (
    .i_instr (INSTR),
    .o_ops   (w_dec)
  );

  assign w_accept = IN_VALID && r_in_ready;
  assign w_drain  = r_out_valid && OUT_READY;

  // Occupancy next-state and register load controls
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_dec  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ST_FULL;
          w_load_out_dec = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_accept && w_drain) begin
          w_load_out_dec = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_state_nxt = ST_SKID;
          w_load_skid = 1'b1;
        end
      end
      ST_SKID: begin
        if (w_drain) begin
          w_state_nxt     = ST_FULL;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State, handshake flags and data registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_SKID);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      if (w_load_out_dec)
        r_out <= w_dec;
      else if (w_load_out_skid)
        r_out <= r_skid;
      if (w_load_skid)
        r_skid <= w_dec;
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign IMM       = r_out.imm;
  assign SHAMT     = r_out.shamt;
  assign DBL       = r_out.dbl;
  assign CTL       = r_out.ctl;

`ifdef IMM_GEN_STATS_EN
  logic [STAT_W-1:0] r_stat_imm;
  logic [STAT_W-1:0] r_stat_shamt;
  logic [STAT_W-1:0] r_stat_dbl;

  // Saturating per-category output-transfer counters; clear wins over increment
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stat_imm   <= '0;
      r_stat_shamt <= '0;
      r_stat_dbl   <= '0;
    end else if (STAT_CLR) begin
      r_stat_imm   <= '0;
      r_stat_shamt <= '0;
      r_stat_dbl   <= '0;
    end else if (w_drain) begin
      case (r_out.ctl)
        IMM_SRC_IMM:   if (r_stat_imm   != '1) r_stat_imm   <= r_stat_imm   + 1'b1;
        IMM_SRC_SHAMT: if (r_stat_shamt != '1) r_stat_shamt <= r_stat_shamt + 1'b1;
        IMM_SRC_DBL:   if (r_stat_dbl   != '1) r_stat_dbl   <= r_stat_dbl   + 1'b1;
        default: ;
      endcase
    end
  end

  assign STAT_IMM   = r_stat_imm;
  assign STAT_SHAMT = r_stat_shamt;
  assign STAT_DBL   = r_stat_dbl;
`endif

endmodule
